// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//   Buffered command front-end for the 8-bit combinational ALU. Commands
//   (operand A, operand B, opcode) arrive over a valid/ready handshake and are
//   queued in a DEPTH-entry circular FIFO. A three-state FSM (IDLE/ISSUE/HOLD)
//   pops one command at a time onto the ALU inputs, waits one settle cycle,
//   captures alu_out into a result register and offers it downstream over a
//   second valid/ready handshake. Opcodes are passed through undecoded.
//
//   Optional feature, macro ALU_CMD_CHAIN_EN: adds input cmd_chain, stored per
//   command. A chained command takes operand A from the most recently captured
//   result instead of its own cmd_a.
//
// Parameters
//   DEPTH  command FIFO depth (power of two, >= 2)
//   W      operand/result width (must match the ALU)
//
// Ports
//   clk, rst_n               rising-edge clock, asynchronous active-low reset
//   cmd_valid/cmd_ready      command handshake
//   cmd_a, cmd_b, cmd_opcode command payload
//   cmd_chain                (ALU_CMD_CHAIN_EN only) take A from last result
//   a, b, opcode             registered drive to the ALU
//   alu_out                  combinational ALU result
//   res_valid/res_ready      result handshake
//   res_data, res_opcode     captured result and the opcode that produced it
//   count                    FIFO occupancy
module alu_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [W-1:0]               cmd_a,
  input  logic [W-1:0]               cmd_b,
  input  logic [2:0]                 cmd_opcode,
`ifdef ALU_CMD_CHAIN_EN
  input  logic                       cmd_chain,
`endif
  output logic [W-1:0]               a,
  output logic [W-1:0]               b,
  output logic [2:0]                 opcode,
  input  logic [W-1:0]               alu_out,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [W-1:0]               res_data,
  output logic [2:0]                 res_opcode,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [2:0]      op_q, op_d;
  logic            res_valid_q, res_valid_d;
  logic [W-1:0]    res_data_q, res_data_d;
  logic [2:0]      res_op_q, res_op_d;

  // FIFO storage: payload only, no reset needed since occupancy guards reads
  logic [W-1:0]    mem_a_q  [DEPTH];
  logic [W-1:0]    mem_b_q  [DEPTH];
  logic [2:0]      mem_op_q [DEPTH];
`ifdef ALU_CMD_CHAIN_EN
  logic            mem_chain_q [DEPTH];
`endif

  logic            push;
  logic            pop;

  // Ready looks only at registered occupancy, so a pop on the same edge
  // cannot let a push into a full FIFO.
  assign cmd_ready = (count_q < DEPTH_C);
  assign push      = cmd_valid && cmd_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a_q[wr_ptr_q]  <= cmd_a;
      mem_b_q[wr_ptr_q]  <= cmd_b;
      mem_op_q[wr_ptr_q] <= cmd_opcode;
`ifdef ALU_CMD_CHAIN_EN
      mem_chain_q[wr_ptr_q] <= cmd_chain;
`endif
    end
  end

  // FSM next-state and result register control
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_op_d    = res_op_q;
    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // ALU inputs have been stable for a full cycle; capture its output.
        res_data_d  = alu_out;
        res_op_d    = op_q;
        res_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Issue registers and FIFO bookkeeping
  always_comb begin
    a_d  = a_q;
    b_d  = b_q;
    op_d = op_q;
    if (pop) begin
`ifdef ALU_CMD_CHAIN_EN
      // res_data_q already holds the previous command's result at pop time.
      a_d = mem_chain_q[rd_ptr_q] ? res_data_q : mem_a_q[rd_ptr_q];
`else
      a_d = mem_a_q[rd_ptr_q];
`endif
      b_d  = mem_b_q[rd_ptr_q];
      op_d = mem_op_q[rd_ptr_q];
    end
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_op_q    <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_op_q    <= res_op_d;
    end
  end

  assign a          = a_q;
  assign b          = b_q;
  assign opcode     = op_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_opcode = res_op_q;
  assign count      = count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
module tb_alu_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int W     = 8;
`ifdef ALU_CMD_CHAIN_EN
  localparam bit CHAIN_EN = 1'b1;
`else
  localparam bit CHAIN_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [W-1:0] cmd_a = '0;
  logic [W-1:0] cmd_b = '0;
  logic [2:0]   cmd_opcode = '0;
  logic         cmd_chain = 1'b0;
  logic [W-1:0] a, b;
  logic [2:0]   opcode;
  logic [W-1:0] alu_out;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] res_data;
  logic [2:0]   res_opcode;
  logic [$clog2(DEPTH):0] count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.DEPTH(DEPTH), .W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_opcode (cmd_opcode),
`ifdef ALU_CMD_CHAIN_EN
    .cmd_chain  (cmd_chain),
`endif
    .a          (a),
    .b          (b),
    .opcode     (opcode),
    .alu_out    (alu_out),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_opcode (res_opcode),
    .count      (count)
  );

  // Stand-in for the combinational ALU
  function automatic logic [W-1:0] alu_f(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic [2:0] op);
    case (op)
      3'd0:    return x & y;
      3'd1:    return x + y;
      3'd2:    return x - y;
      3'd3:    return x | y;
      3'd4:    return x ^ y;
      3'd5:    return ~x;
      3'd6:    return x << 1;
      default: return x >> 1;
    endcase
  endfunction

  assign alu_out = alu_f(a, b, opcode);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: every accepted command yields exactly one result, in order.
  typedef struct packed {
    logic [2:0]   op;
    logic [W-1:0] res;
  } exp_t;

  exp_t         expq[$];
  int           hs_cyc[$];
  logic [W-1:0] last_res = '0;
  int           cyc = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      exp_t         e;
      logic [W-1:0] ea;
      cyc++;
      check("ready_vs_count", {31'd0, cmd_ready}, {31'd0, (count < DEPTH)});
      if (cmd_valid && cmd_ready) begin
        ea       = (CHAIN_EN && cmd_chain) ? last_res : cmd_a;
        e.res    = alu_f(ea, cmd_b, cmd_opcode);
        e.op     = cmd_opcode;
        last_res = e.res;
        expq.push_back(e);
      end
      if (res_valid && res_ready) begin
        hs_cyc.push_back(cyc);
        if (expq.size() == 0) begin
          check("res_unexpected", 32'd1, 32'd0);
        end else begin
          e = expq.pop_front();
          check("res_data", {24'd0, res_data}, {24'd0, e.res});
          check("res_opcode", {29'd0, res_opcode}, {29'd0, e.op});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [2:0] top,
                       input logic tch);
    cmd_valid  = 1'b1;
    cmd_a      = ta;
    cmd_b      = tb;
    cmd_opcode = top;
    cmd_chain  = tch;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    expq.delete();
    last_res  = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_a"}, {24'd0, a}, 32'd0);
    check({tag, "_b"}, {24'd0, b}, 32'd0);
    check({tag, "_opcode"}, {29'd0, opcode}, 32'd0);
    check({tag, "_res_data"}, {24'd0, res_data}, 32'd0);
    check({tag, "_res_opcode"}, {29'd0, res_opcode}, 32'd0);
    check({tag, "_res_valid"}, {31'd0, res_valid}, 32'd0);
    check({tag, "_count"}, {29'd0, count}, 32'd0);
    check({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic drain(input string tag);
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 80 && !(expq.size() == 0 && !res_valid && count == 0); i++) tick();
    check({tag, "_drained"}, expq.size(), 32'd0);
    check({tag, "_idle_valid"}, {31'd0, res_valid}, 32'd0);
  endtask

  initial begin
    logic acc;
    logic saw;
    logic [W-1:0] ba [6];
    logic [W-1:0] bb [6];
    logic [2:0]   bo [6];

    // Reset values
    tick(); tick();
    check_reset_outputs("rst0");
    rst_n = 1'b1;

    // Single command: A=1, B=2, add
    res_ready = 1'b1;
    drive(8'h01, 8'h02, 3'b001, 1'b0);
    tick();                                    // edge k
    cmd_valid = 1'b0;
    check("single_count_k", {29'd0, count}, 32'd1);
    check("single_a_k", {24'd0, a}, 32'd0);
    tick();                                    // edge k+1
    check("single_a_k1", {24'd0, a}, 32'h01);
    check("single_b_k1", {24'd0, b}, 32'h02);
    check("single_op_k1", {29'd0, opcode}, 32'd1);
    check("single_valid_k1", {31'd0, res_valid}, 32'd0);
    tick();                                    // edge k+2
    check("single_valid_k2", {31'd0, res_valid}, 32'd1);
    check("single_data_k2", {24'd0, res_data}, 32'h03);
    check("single_resop_k2", {29'd0, res_opcode}, 32'd1);
    tick();                                    // handshake
    check("single_valid_after_hs", {31'd0, res_valid}, 32'd0);
    check("single_data_held", {24'd0, res_data}, 32'h03);
    drain("single");

    // Backpressure and full-boundary push
    for (int i = 0; i < 6; i++) begin
      ba[i] = 8'(8'h10 + 8'(i * 17));
      bb[i] = 8'(8'h03 + 8'(i));
      bo[i] = 3'(i + 1);
    end
    res_ready = 1'b0;
    hs_cyc.delete();
    for (int i = 0; i < 6; i++) begin
      drive(ba[i], bb[i], bo[i], 1'b0);
      tick();
    end
    check("bp_count_full", {29'd0, count}, 32'd4);
    check("bp_ready_low", {31'd0, cmd_ready}, 32'd0);
    check("bp_res_valid", {31'd0, res_valid}, 32'd1);
    check("bp_first_result", {24'd0, res_data}, {24'd0, alu_f(ba[0], bb[0], bo[0])});
    // Command 5 (index 5) is still offered while the handshake pops.
    res_ready = 1'b1;
    tick();
    check("full_push_count", {29'd0, count}, 32'd3);
    check("full_push_ready", {31'd0, cmd_ready}, 32'd1);
    check("full_push_a", {24'd0, a}, {24'd0, ba[1]});
    tick();
    cmd_valid = 1'b0;
    check("full_retry_count", {29'd0, count}, 32'd4);
    drain("bp");
    check("bp_num_results", hs_cyc.size(), 32'd6);
    for (int k = 1; k < hs_cyc.size(); k++)
      check("bp_spacing", hs_cyc[k] - hs_cyc[k-1], 32'd2);

    // Empty-boundary push: new command lands on the HOLD handshake edge
    res_ready = 1'b0;
    drive(8'h21, 8'h0F, 3'b100, 1'b0);
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    check("eb_hold_valid", {31'd0, res_valid}, 32'd1);
    check("eb_hold_count", {29'd0, count}, 32'd0);
    drive(8'h5A, 8'h33, 3'b011, 1'b0);
    res_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("eb_idle_valid", {31'd0, res_valid}, 32'd0);
    check("eb_idle_count", {29'd0, count}, 32'd1);
    check("eb_idle_a_held", {24'd0, a}, 32'h21);
    tick();
    check("eb_issue_a", {24'd0, a}, 32'h5A);
    check("eb_issue_count", {29'd0, count}, 32'd0);
    tick();
    check("eb_result_valid", {31'd0, res_valid}, 32'd1);
    check("eb_result_data", {24'd0, res_data}, {24'd0, (8'h5A | 8'h33)});
    drain("eb");

    // Chaining: second command takes A from the first result when enabled
    res_ready = 1'b1;
    drive(8'h01, 8'h02, 3'b001, 1'b0);
    tick();
    drive(8'h77, 8'h05, 3'b001, 1'b1);
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    check("chain_a", {24'd0, a}, CHAIN_EN ? 32'h03 : 32'h77);
    check("chain_b", {24'd0, b}, 32'h05);
    drain("chain");
    cmd_chain = 1'b0;

    // Reset mid-operation with 3 commands queued
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(8'(8'h40 + 8'(i)), 8'h01, 3'b010, 1'b0);
      tick();
    end
    check("mid_count_before", {29'd0, count}, 32'd3);
    do_reset();
    #1;
    check_reset_outputs("mid_rst");
    res_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      saw = saw | res_valid;
    end
    check("mid_no_res_after", {31'd0, saw}, 32'd0);

    // Randomized traffic; a refused command is held until accepted
    acc = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (!cmd_valid || acc) begin
        cmd_valid  = ($urandom_range(0, 2) != 0);
        cmd_a      = 8'($urandom);
        cmd_b      = 8'($urandom);
        cmd_opcode = 3'($urandom);
        cmd_chain  = ($urandom_range(0, 3) == 0);
      end
      res_ready = ($urandom_range(0, 3) != 0);
      acc = cmd_valid && cmd_ready;
      tick();
    end
    drain("rand");
    check("rand_count_zero", {29'd0, count}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
